// File: rtl/giga_mc_pkg.sv
// ============================================================================
// Module  : giga_mc_pkg
// Purpose : State, opcode and datapath-select encodings shared by the
//           giga_mc multi-cycle control sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package giga_mc_pkg;

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_BRANCH = 3'd5;
    localparam logic [2:0] c_ST_JUMP   = 3'd6;
    localparam logic [2:0] c_ST_FAULT  = 3'd7;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_J     = 6'h02;

    localparam logic [1:0] c_ALUB_RT      = 2'd0;
    localparam logic [1:0] c_ALUB_FOUR    = 2'd1;
    localparam logic [1:0] c_ALUB_IMM     = 2'd2;
    localparam logic [1:0] c_ALUB_IMM_SH2 = 2'd3;

    localparam logic [1:0] c_ALUOP_ADD   = 2'd0;
    localparam logic [1:0] c_ALUOP_SUB   = 2'd1;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] c_PCSRC_ALU    = 2'd0;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'd2;

    // State following DECODE; unknown opcodes land in FAULT.
    function automatic logic [2:0] decode_next(input logic [5:0] op);
        logic [2:0] nxt;
        case (op)
            c_OP_RTYPE, c_OP_ADDI, c_OP_LW, c_OP_SW: nxt = c_ST_EXEC;
            c_OP_BEQ:                                nxt = c_ST_BRANCH;
            c_OP_J:                                  nxt = c_ST_JUMP;
            default:                                 nxt = c_ST_FAULT;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/giga_mc_sequencer_wait_timer.sv
// ============================================================================
// Module  : giga_mc_wait_timer
// Purpose : Memory wait-state watchdog; flags the cycle in which an un-acked
//           request reaches MEM_TIMEOUT cycles (MEM_TIMEOUT=0 disables it).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module giga_mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    output logic expire
);

    generate
        if (MEM_TIMEOUT > 0) begin : g_wdog
            localparam logic [TMR_W-1:0] c_LAST = TMR_W'(MEM_TIMEOUT - 1);
            logic [TMR_W-1:0] r_count;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_count <= '0;
                end else if (clr) begin
                    r_count <= '0;
                end else if (cnt_en) begin
                    r_count <= r_count + TMR_W'(1);
                end
            end

            // Expiry only on an un-acked cycle, so a same-cycle ack wins.
            assign expire = cnt_en && (r_count == c_LAST);
        end else begin : g_no_wdog
            assign expire = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/giga_mc_sequencer.sv
// ============================================================================
// Module  : giga_mc_sequencer
// Purpose : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the
//           mini-MIPS core. Optional GIGA_MC_PERF_CNT_EN adds perf counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module giga_mc_sequencer
    import giga_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 8
`ifdef GIGA_MC_PERF_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [2:0] state,
    output logic       retired,
    output logic       fault,
    output logic       illegal_op
`ifdef GIGA_MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [5:0] r_opcode;
    logic       r_imem_pend;
    logic       r_illegal;
    logic       w_illegal_set;
    logic       w_imem_req;
    logic       w_dmem_req;
    logic       w_imem_hit;
    logic       w_dmem_hit;
    logic       w_wait;
    logic       w_expire;

    // Gating with rst keeps the fetch request low for the whole reset pulse.
    assign w_imem_req = (r_state == c_ST_FETCH) && rst && (run || r_imem_pend);
    assign w_dmem_req = (r_state == c_ST_MEM);
    assign w_imem_hit = w_imem_req && imem_ack;
    assign w_dmem_hit = w_dmem_req && dmem_ack;
    assign w_wait     = (w_imem_req && !imem_ack) || (w_dmem_req && !dmem_ack);

    giga_mc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_imem_hit || w_dmem_hit || (w_state_next != r_state)),
        .cnt_en (w_wait),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_FETCH;
            r_opcode    <= '0;
            r_imem_pend <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_imem_pend <= w_imem_req && !imem_ack;
            if (r_state == c_ST_DECODE) begin
                r_opcode <= opcode;
            end
            if (w_illegal_set) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_illegal_set = 1'b0;
        pc_we         = 1'b0;
        ir_we         = 1'b0;
        reg_we        = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = c_ALUB_RT;
        alu_op        = c_ALUOP_ADD;
        pc_src        = c_PCSRC_ALU;
        dmem_we       = 1'b0;
        retired       = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                if (w_imem_hit) begin
                    ir_we        = 1'b1;
                    pc_we        = 1'b1;
                    alu_src_b    = c_ALUB_FOUR;
                    w_state_next = c_ST_DECODE;
                end else if (w_expire) begin
                    w_state_next = c_ST_FAULT;
                end
            end
            c_ST_DECODE: begin
                alu_src_b     = c_ALUB_IMM_SH2;
                w_state_next  = decode_next(opcode);
                w_illegal_set = (decode_next(opcode) == c_ST_FAULT);
            end
            c_ST_EXEC: begin
                alu_src_a = 1'b1;
                case (r_opcode)
                    c_OP_RTYPE: begin
                        alu_op       = c_ALUOP_FUNCT;
                        w_state_next = c_ST_WB;
                    end
                    c_OP_ADDI: begin
                        alu_src_b    = c_ALUB_IMM;
                        w_state_next = c_ST_WB;
                    end
                    c_OP_LW, c_OP_SW: begin
                        alu_src_b    = c_ALUB_IMM;
                        w_state_next = c_ST_MEM;
                    end
                    default: w_state_next = c_ST_FAULT;
                endcase
            end
            c_ST_MEM: begin
                dmem_we = (r_opcode == c_OP_SW);
                if (w_dmem_hit) begin
                    if (r_opcode == c_OP_SW) begin
                        retired      = 1'b1;
                        w_state_next = c_ST_FETCH;
                    end else begin
                        w_state_next = c_ST_WB;
                    end
                end else if (w_expire) begin
                    w_state_next = c_ST_FAULT;
                end
            end
            c_ST_WB: begin
                reg_we       = 1'b1;
                reg_dst      = (r_opcode == c_OP_RTYPE);
                mem_to_reg   = (r_opcode == c_OP_LW);
                retired      = 1'b1;
                w_state_next = c_ST_FETCH;
            end
            c_ST_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = c_ALUOP_SUB;
                pc_src       = c_PCSRC_ALUOUT;
                pc_we        = zero;
                retired      = 1'b1;
                w_state_next = c_ST_FETCH;
            end
            c_ST_JUMP: begin
                pc_src       = c_PCSRC_JUMP;
                pc_we        = 1'b1;
                retired      = 1'b1;
                w_state_next = c_ST_FETCH;
            end
            default: w_state_next = c_ST_FAULT;
        endcase
    end

    assign imem_req   = w_imem_req;
    assign dmem_req   = w_dmem_req;
    assign state      = r_state;
    assign fault      = (r_state == c_ST_FAULT);
    assign illegal_op = r_illegal;

`ifdef GIGA_MC_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (r_state != c_ST_FAULT) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (retired) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

    a_req_exclusive: assert property (@(posedge clk) disable iff (!rst) !(imem_req && dmem_req));
    a_we_exclusive:  assert property (@(posedge clk) disable iff (!rst) !(pc_we && reg_we));

endmodule

`default_nettype wire

// File: tb/tb_giga_mc_sequencer.sv
// ============================================================================
// Module  : tb_giga_mc_sequencer
// Purpose : Scoreboard bench for giga_mc_sequencer; per-cycle expected output
//           vectors are queued with their stimulus and compared as they occur.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_giga_mc_sequencer;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3;
    localparam logic [2:0] S_W = 3'd4, S_B = 3'd5, S_J = 3'd6, S_X = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       imem_req, dmem_req, dmem_we, pc_we, ir_we, reg_we, reg_dst;
    logic       mem_to_reg, alu_src_a, retired, fault, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [2:0] state;
`ifdef GIGA_MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    giga_mc_sequencer #(
        .MEM_TIMEOUT (16),
        .TMR_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .zero       (zero),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .state      (state),
        .retired    (retired),
        .fault      (fault),
        .illegal_op (illegal_op)
`ifdef GIGA_MC_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, dmem_req, dmem_we, pc_we, ir_we;
        logic       reg_we, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       retired, fault, illegal;
    } exp_t;

    typedef struct packed {
        logic run, iack, dack;
    } drv_t;

    exp_t exp_q[$];
    drv_t drv_q[$];

    function automatic exp_t sample();
        exp_t a;
        a.st = state;       a.imem_req = imem_req; a.dmem_req = dmem_req;
        a.dmem_we = dmem_we; a.pc_we = pc_we;      a.ir_we = ir_we;
        a.reg_we = reg_we;  a.reg_dst = reg_dst;   a.mem_to_reg = mem_to_reg;
        a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b; a.alu_op = alu_op;
        a.pc_src = pc_src;  a.retired = retired;   a.fault = fault;
        a.illegal = illegal_op;
        return a;
    endfunction

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e = '0;
        e.st = st;
        return e;
    endfunction

    task automatic push(input exp_t e, input logic r, input logic ia, input logic da);
        drv_t d;
        d.run = r; d.iack = ia; d.dack = da;
        exp_q.push_back(e);
        drv_q.push_back(d);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction with the given
    // fetch/data wait states; spur drives acks while the matching req is low.
    task automatic queue_instr(input logic [5:0] op, input int iw, input int dw,
                               input logic z, input logic spur);
        exp_t e;
        for (int i = 0; i < iw; i++) begin
            e = blank(S_F); e.imem_req = 1'b1;
            push(e, 1'b1, 1'b0, spur);
        end
        e = blank(S_F); e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.alu_src_b = 2'd1;
        push(e, 1'b1, 1'b1, spur);
        e = blank(S_D); e.alu_src_b = 2'd3;
        push(e, 1'($urandom_range(0, 1)), spur, 1'b0);
        case (op)
            6'h00, 6'h08: begin
                e = blank(S_E); e.alu_src_a = 1'b1;
                e.alu_src_b = (op == 6'h00) ? 2'd0 : 2'd2;
                e.alu_op    = (op == 6'h00) ? 2'd2 : 2'd0;
                push(e, 1'($urandom_range(0, 1)), spur, spur);
                e = blank(S_W); e.reg_we = 1'b1; e.reg_dst = (op == 6'h00); e.retired = 1'b1;
                push(e, 1'($urandom_range(0, 1)), spur, spur);
            end
            6'h23, 6'h2B: begin
                e = blank(S_E); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                push(e, 1'($urandom_range(0, 1)), spur, spur);
                for (int i = 0; i <= dw; i++) begin
                    e = blank(S_M); e.dmem_req = 1'b1; e.dmem_we = (op == 6'h2B);
                    e.retired = (op == 6'h2B) && (i == dw);
                    push(e, 1'($urandom_range(0, 1)), spur, (i == dw));
                end
                if (op == 6'h23) begin
                    e = blank(S_W); e.reg_we = 1'b1; e.mem_to_reg = 1'b1; e.retired = 1'b1;
                    push(e, 1'($urandom_range(0, 1)), spur, spur);
                end
            end
            6'h04: begin
                e = blank(S_B); e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.pc_src = 2'd1;
                e.pc_we = z; e.retired = 1'b1;
                push(e, 1'($urandom_range(0, 1)), spur, spur);
            end
            6'h02: begin
                e = blank(S_J); e.pc_src = 2'd2; e.pc_we = 1'b1; e.retired = 1'b1;
                push(e, 1'($urandom_range(0, 1)), spur, spur);
            end
            default: begin
                for (int i = 0; i < 2; i++) begin
                    e = blank(S_X); e.fault = 1'b1; e.illegal = 1'b1;
                    push(e, 1'b1, 1'b1, 1'b1);
                end
            end
        endcase
    endtask

    // One queue entry per clock: drive on the falling edge, compare 1 ns later.
    task automatic drain(input string name);
        exp_t e, a;
        drv_t d;
        int   cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = drv_q.pop_front();
            @(negedge clk);
            run = d.run; imem_ack = d.iack; dmem_ack = d.dack;
            #1;
            a = sample();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs got %h expected %h", name, cyc, a, e);
            end
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t a;
        rst = 1'b0; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        a = sample();
        checks++;
        if (a !== blank(S_F)) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", a, blank(S_F));
        end
        @(negedge clk);
        run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; rst = 1'b1;
    endtask

    task automatic test_rtype();
        opcode = 6'h00;
        queue_instr(6'h00, 0, 0, 1'b0, 1'b0);
        drain("rtype");
    endtask

    task automatic test_lw_wait();
        opcode = 6'h23;
        queue_instr(6'h23, 0, 3, 1'b0, 1'b1);
        drain("lw_wait3");
    endtask

    task automatic test_beq();
        opcode = 6'h04; zero = 1'b1;
        queue_instr(6'h04, 0, 0, 1'b1, 1'b0);
        drain("beq_taken");
        zero = 1'b0;
        queue_instr(6'h04, 1, 0, 1'b0, 1'b0);
        drain("beq_not_taken");
    endtask

    task automatic test_halt();
        exp_t e;
        opcode = 6'h02;
        push(blank(S_F), 1'b0, 1'b1, 1'b0);
        push(blank(S_F), 1'b0, 1'b0, 1'b0);
        e = blank(S_F); e.imem_req = 1'b1;
        push(e, 1'b1, 1'b0, 1'b0);
        push(e, 1'b0, 1'b0, 1'b0);
        e.ir_we = 1'b1; e.pc_we = 1'b1; e.alu_src_b = 2'd1;
        push(e, 1'b0, 1'b1, 1'b0);
        e = blank(S_D); e.alu_src_b = 2'd3;
        push(e, 1'b0, 1'b0, 1'b0);
        e = blank(S_J); e.pc_src = 2'd2; e.pc_we = 1'b1; e.retired = 1'b1;
        push(e, 1'b0, 1'b0, 1'b0);
        push(blank(S_F), 1'b0, 1'b0, 1'b0);
        drain("halt_hold");
    endtask

    task automatic test_back_to_back();
        opcode = 6'h08;
        queue_instr(6'h08, 2, 0, 1'b0, 1'b0);
        drain("b2b_addi");
        opcode = 6'h2B;
        queue_instr(6'h2B, 0, 1, 1'b0, 1'b1);
        drain("b2b_sw");
        opcode = 6'h00;
        queue_instr(6'h00, 1, 0, 1'b0, 1'b0);
        drain("b2b_rtype");
        opcode = 6'h02;
        queue_instr(6'h02, 0, 0, 1'b0, 1'b1);
        drain("b2b_j");
    endtask

    task automatic test_timeout_ack();
        opcode = 6'h02;
        queue_instr(6'h02, 15, 0, 1'b0, 1'b0);
        drain("timeout_ack_wins");
    endtask

    task automatic test_timeout_fault();
        exp_t e;
        e = blank(S_F); e.imem_req = 1'b1;
        for (int i = 0; i < 16; i++) push(e, 1'b1, 1'b0, 1'b0);
        e = blank(S_X); e.fault = 1'b1;
        for (int i = 0; i < 3; i++) push(e, 1'b1, 1'b1, 1'b1);
        drain("timeout_fault");
    endtask

    task automatic test_illegal_op();
        do_reset();
        opcode = 6'h3F;
        queue_instr(6'h3F, 0, 0, 1'b0, 1'b0);
        drain("illegal_op");
    endtask

    task automatic test_reset_mid_mem();
        exp_t e, a;
        do_reset();
        opcode = 6'h23;
        e = blank(S_F); e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.alu_src_b = 2'd1;
        push(e, 1'b1, 1'b1, 1'b0);
        e = blank(S_D); e.alu_src_b = 2'd3;
        push(e, 1'b1, 1'b0, 1'b0);
        e = blank(S_E); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
        push(e, 1'b1, 1'b0, 1'b0);
        e = blank(S_M); e.dmem_req = 1'b1;
        push(e, 1'b1, 1'b0, 1'b0);
        push(e, 1'b1, 1'b0, 1'b0);
        drain("lw_to_mem");
        #1 rst = 1'b0;
        #1;
        a = sample();
        checks++;
        if (a !== blank(S_F)) begin
            errors++;
            $display("FAIL async_reset_mid_mem: got %h expected %h", a, blank(S_F));
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (dmem_req !== 1'b0 || state !== S_F || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: dmem_req=%b imem_req=%b state=%0d expected 0 0 0",
                     dmem_req, imem_req, state);
        end
        rst = 1'b1; run = 1'b0;
    endtask

`ifdef GIGA_MC_PERF_CNT_EN
    task automatic test_perf_cnt();
        do_reset();
        rst = 1'b0;
        @(negedge clk);
        opcode = 6'h02; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: cycle_cnt=%0d instr_cnt=%0d expected 0 0", cycle_cnt, instr_cnt);
        end
        repeat (30) @(negedge clk);
        #1;
        checks++;
        if (cycle_cnt !== 32'd30 || instr_cnt !== 32'd10 || state !== S_F) begin
            errors++;
            $display("FAIL perf_10_jumps: cycle_cnt=%0d instr_cnt=%0d state=%0d expected 30 10 0",
                     cycle_cnt, instr_cnt, state);
        end
        run = 1'b0; imem_ack = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_halt();
        test_back_to_back();
        test_timeout_ack();
        test_timeout_fault();
        test_illegal_op();
        test_reset_mid_mem();
`ifdef GIGA_MC_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/giga_mc_sequencer.md
Name: giga_mc_sequencer

Overview:
- Multi-cycle control sequencer for the next-generation mini-MIPS core; replaces the combinational single-cycle control unit.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Talks to instruction and data memory over req/ack handshakes with wait-state tolerance and a timeout watchdog.
- Drives the datapath mux selects and write enables; the datapath (PC, IR, register file, ALU) stays outside this block.

Parameters:
- MEM_TIMEOUT, 16, cycles a memory req may remain un-acked before FAULT; 0 disables the watchdog.
- TMR_W, 8, width of the wait counter; must satisfy 2^TMR_W > MEM_TIMEOUT.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  permits a new fetch; low = halt at the instruction boundary.
- opcode  in  6  IR[31:26], stable from DECODE onward.
- zero  in  1  ALU zero flag.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction memory ack; IR data valid in the same cycle.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (sw); valid while dmem_req=1.
- dmem_ack  in  1  data memory ack.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- reg_we  out  1  GPR write enable.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- alu_op  out  2  0 = add, 1 = sub, 2 = funct-decoded.
- pc_src  out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target.
- state  out  3  current state encoding.
- retired  out  1  one-cycle pulse when an instruction completes.
- fault  out  1  sticky FAULT indicator.
- illegal_op  out  1  sticky: fault was caused by an unknown opcode.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FETCH.
  - All outputs 0, wait counter 0, latched opcode 0.
  - Any request in flight is dropped immediately.
- FETCH:
  - imem_req asserts when run=1.
  - Once asserted, imem_req holds until imem_ack regardless of run; no req drop before ack.
  - Ack cycle: ir_we=1, pc_we=1, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0; next state DECODE.
- DECODE:
  - Latches opcode; drives alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut).
  - Next state by opcode:
    - 0x00, 0x08, 0x23, 0x2B -> EXEC.
    - 0x04 -> BRANCH.
    - 0x02 -> JUMP.
    - Any other -> FAULT with illegal_op=1.
- EXEC, by latched opcode:
  - R-type: alu_src_a=1, alu_src_b=0, alu_op=2; next WB.
  - addi: alu_src_a=1, alu_src_b=2, alu_op=0; next WB.
  - lw/sw: alu_src_a=1, alu_src_b=2, alu_op=0; next MEM.
- MEM:
  - dmem_req=1, dmem_we=1 for sw, held until dmem_ack.
  - On ack: lw -> WB; sw -> FETCH with retired=1.
- WB:
  - reg_we=1, one cycle.
  - reg_dst=1 for R-type, 0 otherwise; mem_to_reg=1 for lw only.
  - retired=1; next FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1.
  - pc_we=zero.
  - retired=1; next FETCH.
- JUMP: pc_src=2, pc_we=1, retired=1; next FETCH.
- Minimum latency (zero wait states):
  - beq and j: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait state adds 1 cycle.
- Watchdog:
  - The wait counter counts cycles with imem_req|dmem_req high and no ack; it clears on ack or state change.
  - counter==MEM_TIMEOUT (MEM_TIMEOUT>0) -> FAULT. An ack arriving in that same cycle wins over the timeout.
- FAULT:
  - Absorbing state: all enables and requests 0, fault=1.
  - Left only by reset.
- Other rules:
  - An ack while the corresponding req=0 is ignored.
  - run has no effect outside FETCH.
- Illegal output combinations (assertion checks):
  - imem_req and dmem_req both high.
  - pc_we and reg_we both high.

Optional Feature:
- GIGA_MC_PERF_CNT_EN defined:
  - Adds outputs cycle_cnt[CNT_W] and instr_cnt[CNT_W], reset to 0.
  - cycle_cnt increments every cycle except in FAULT.
  - instr_cnt increments on retired.
  - Both wrap modulo 2^CNT_W.
- Undefined: the ports and logic are absent.

Decomposition:
- Package giga_mc_pkg holds:
  - State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, JUMP=6, FAULT=7.
  - Opcode constants: OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J.
  - alu_src_b, alu_op and pc_src encodings.
- One sub-module, giga_mc_wait_timer: a clear/count/expire counter parametrised by MEM_TIMEOUT and TMR_W.

Test Plan:
- Reset, then run=1, opcode=0x00, imem_ack in 1st req cycle -> states F,D,E,WB; reg_we=1 and reg_dst=1 in cycle 4; retired pulse once.
- lw (0x23), dmem_ack after 3 wait cycles -> 8-cycle instruction; mem_to_reg=1 in WB; dmem_we=0 throughout.
- beq (0x04): zero=1 -> pc_we=1, pc_src=1 in cycle 3; repeat with zero=0 -> pc_we=0; both retire.
- imem_req held with no ack, MEM_TIMEOUT=16 -> FAULT after 16 wait cycles, fault=1, imem_req=0; an ack on cycle 16 instead -> DECODE.
- opcode=0x3F -> FAULT, illegal_op=1; pulse rst low mid-MEM -> dmem_req drops asynchronously, state=FETCH.
- With GIGA_MC_PERF_CNT_EN: 10 back-to-back j instructions -> instr_cnt=10, cycle_cnt=30.
